ps2_scan_fifo: RTL and testbench

PS2_SCAN_FIFO -- requirements
Module: ps2_scan_fifo

---
 rtl/ps2_scan_fifo.sv | 189 ++++++++++++++++++
 tb/tb_ps2_scan_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_fifo.sv
// rtl/ps2_scan_fifo.sv - PS/2 scan-code receiver with break-code filter and FIFO
//
// Receives PS/2 keyboard frames, drops released-key codes (F0 xx) and queues the rest.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2c, ps2d      asynchronous PS/2 clock and data lines
//   rd_fifo         pop the FIFO head (ignored while empty)
//   rd_data         FIFO head byte, first-word fall-through
//   fifo_empty      FIFO holds no entries
//   fifo_full       FIFO holds 2^FIFO_AW entries
//   rx_data         last validly framed byte (any code)
//   rx_done_tick    one-cycle pulse per validly framed byte
//   breakcode       one-cycle pulse when a released-key code is dropped
//   overflow        sticky, a byte was lost to a full FIFO
module ps2_scan_fifo #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 65536,
  parameter int FIFO_AW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd_fifo,
  output logic [7:0] rd_data,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_done_tick,
  output logic       breakcode,
  output logic       overflow
);

  localparam int FCW   = $clog2(FILT_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, LOAD} state_t;

  // Synchronizers and clock filter
  logic           c_s1, c_s2, d_s1, d_s2;
  logic           c_filt, c_filt_d;
  logic [FCW-1:0] filt_cnt;
  logic           fall;

  // Receiver
  state_t         state;
  logic [3:0]     bit_cnt;
  logic [10:0]    frame;
  logic [TW-1:0]  to_cnt;
  logic           break_pend;
  logic           wr_req;
  logic [10:0]    frame_nx;
  logic           frame_ok;
  logic [7:0]     byte_nx;

  // FIFO
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1     <= 1'b1;
      c_s2     <= 1'b1;
      d_s1     <= 1'b1;
      d_s2     <= 1'b1;
      c_filt   <= 1'b1;
      c_filt_d <= 1'b1;
      filt_cnt <= '0;
    end else begin
      c_s1     <= ps2c;
      c_s2     <= c_s1;
      d_s1     <= ps2d;
      d_s2     <= d_s1;
      c_filt_d <= c_filt;
      // filt_cnt counts consecutive samples that disagree with the filtered level
      if (c_s2 == c_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
        c_filt   <= c_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = c_filt_d & ~c_filt;

  // Frame as it will look after shifting in the current data bit. The start bit
  // is shifted in from IDLE, so after ten more strobes frame[0] is the start bit.
  always_comb begin
    frame_nx = {d_s2, frame[10:1]};
    byte_nx  = frame_nx[8:1];
    frame_ok = ~frame_nx[0] & frame_nx[10] & (^frame_nx[9:1]);
  end

  // bit_cnt holds the number of frame bits still to come after the start bit.
  // Tick, rx_data and break classification are registered on the final strobe
  // so they are visible during the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame        <= '0;
      to_cnt       <= '0;
      break_pend   <= 1'b0;
      wr_req       <= 1'b0;
      rx_data      <= 8'h00;
      rx_done_tick <= 1'b0;
      breakcode    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      breakcode    <= 1'b0;
      wr_req       <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && !d_s2) begin
            frame   <= frame_nx;
            bit_cnt <= 4'd10;
            to_cnt  <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (fall) begin
            frame   <= frame_nx;
            bit_cnt <= bit_cnt - 4'd1;
            to_cnt  <= '0;
            if (bit_cnt == 4'd1) begin
              state <= LOAD;
              if (frame_ok) begin
                rx_done_tick <= 1'b1;
                rx_data      <= byte_nx;
                if (byte_nx == 8'hF0 && !break_pend) begin
                  break_pend <= 1'b1;
                end else if (break_pend) begin
                  // released-key target (a second F0 counts as one too)
                  break_pend <= 1'b0;
                  breakcode  <= 1'b1;
                end else begin
                  wr_req <= 1'b1;
                end
              end
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO: rx_data already holds the byte during the wr_req cycle
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_rd      = rd_fifo & ~fifo_empty;
  assign do_wr      = wr_req & (~fifo_full | do_rd);
  assign rd_data    = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr_req && !do_wr) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[FIFO_AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb/tb_ps2_scan_fifo.sv - self-checking bench for ps2_scan_fifo
module tb_ps2_scan_fifo;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 600;
  localparam int FIFO_AW  = 4;
  localparam int DEPTH    = 2 ** FIFO_AW;

  logic       clk, rst, ps2c, ps2d, rd_fifo;
  logic [7:0] rd_data, rx_data;
  logic       fifo_empty, fifo_full, rx_done_tick, breakcode, overflow;

  ps2_scan_fifo #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .rd_fifo(rd_fifo),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .rx_data(rx_data), .rx_done_tick(rx_done_tick), .breakcode(breakcode),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Observed event counters
  int         tick_cnt = 0, brk_cnt = 0, brk_orphan = 0;
  logic       tick_prev = 1'b0;
  logic       tick_empty = 1'b0, post_empty = 1'b1;
  logic [7:0] post_rd = 8'h00;

  always @(negedge clk) begin
    if (tick_prev) begin
      post_empty = fifo_empty;
      post_rd    = rd_data;
    end
    if (rx_done_tick === 1'b1) begin
      tick_cnt++;
      tick_empty = fifo_empty;
    end
    if (breakcode === 1'b1) brk_cnt++;
    if (breakcode === 1'b1 && rx_done_tick !== 1'b1) brk_orphan++;
    tick_prev = (rx_done_tick === 1'b1);
  end

  // Reference model
  logic [7:0] q[$];
  bit         bp = 0, ovf_m = 0;
  int         ticks_m = 0, brk_m = 0;
  logic [7:0] last_m = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_byte(input logic [7:0] b);
    ticks_m++;
    last_m = b;
    if (bp) begin
      bp = 0;
      brk_m++;
    end else if (b == 8'hF0) begin
      bp = 1;
    end else if (q.size() < DEPTH) begin
      q.push_back(b);
    end else begin
      ovf_m = 1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    repeat (20) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2d = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic send_valid(input logic [7:0] b);
    send_raw(b, 1'b0, 11);
    model_byte(b);
  endtask

  // Pops the FIFO in the very cycle the byte is written
  task automatic send_with_tick_read(input string tag, input logic [7:0] b);
    bit         seen;
    logic [7:0] head;
    seen = 0;
    head = 8'h00;
    fork
      send_raw(b, 1'b0, 11);
      begin
        for (int i = 0; i < 600 && !seen; i++) begin
          @(negedge clk);
          if (rx_done_tick === 1'b1) begin
            seen    = 1;
            head    = rd_data;
            rd_fifo = 1'b1;
            @(negedge clk);
            rd_fifo = 1'b0;
          end
        end
      end
    join
    check({tag, "_tick_seen"}, 32'(seen), 32'd1);
    if (q.size() > 0) begin
      check({tag, "_head"}, 32'(head), 32'(q[0]));
      void'(q.pop_front());
    end
    model_byte(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ticks"},    tick_cnt, ticks_m);
    check({tag, "_breaks"},   brk_cnt, brk_m);
    check({tag, "_orphan"},   brk_orphan, 0);
    check({tag, "_rx_data"},  32'(rx_data), 32'(last_m));
    check({tag, "_empty"},    32'(fifo_empty), 32'(q.size() == 0));
    check({tag, "_full"},     32'(fifo_full), 32'(q.size() == DEPTH));
    check({tag, "_overflow"}, 32'(overflow), 32'(ovf_m));
    if (q.size() > 0) check({tag, "_head"}, 32'(rd_data), 32'(q[0]));
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    exp = q.pop_front();
    check({tag, "_rd_data"}, 32'(rd_data), 32'(exp));
    @(negedge clk);
    rd_fifo = 1'b1;
    @(negedge clk);
    rd_fifo = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_check(tag);
    @(negedge clk);
    check({tag, "_drained_empty"}, 32'(fifo_empty), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    bp = 0;
    ovf_m = 0;
    last_m = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rd_fifo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_breakcode", 32'(breakcode), 32'd0);
    check_state("reset");

    // Single frame, fall-through timing
    send_valid(8'h1C);
    check("fwft_tick_empty", 32'(tick_empty), 32'd1);
    check("fwft_post_empty", 32'(post_empty), 32'd0);
    check("fwft_post_rd", 32'(post_rd), 32'h1C);
    check_state("single");
    drain("single");

    // Read while empty is ignored
    @(negedge clk); rd_fifo = 1'b1; @(negedge clk); rd_fifo = 1'b0;
    send_valid(8'h55);
    check_state("rd_empty");
    drain("rd_empty");

    // Make / break sequence
    send_valid(8'h1C); send_valid(8'hF0); send_valid(8'h1C);
    check_state("brk_seq");
    check("brk_seq_depth", 32'(fifo_empty), 32'd0);
    drain("brk_seq");

    // Extended codes
    send_valid(8'hE0); send_valid(8'h75); send_valid(8'hE0);
    send_valid(8'hF0); send_valid(8'h75);
    check_state("ext_seq");
    drain("ext_seq");

    // Double F0: second is itself the break target
    send_valid(8'hF0); send_valid(8'hF0); send_valid(8'h33);
    check_state("dbl_f0");
    drain("dbl_f0");

    // Bad parity, stalled frame, then a good byte
    send_raw(8'h1C, 1'b1, 11);
    check_state("bad_par");
    send_raw(8'h1C, 1'b0, 4);
    repeat (TIMEOUT + 100) @(negedge clk);
    check_state("stall");
    send_valid(8'h2D);
    check_state("after_stall");
    drain("after_stall");

    // Write with read while empty
    send_with_tick_read("wr_rd_empty", 8'h44);
    check_state("wr_rd_empty");
    drain("wr_rd_empty");

    // Fill, write+read while full, then overflow
    for (int i = 1; i <= DEPTH; i++) send_valid(8'(i));
    check_state("filled");
    send_with_tick_read("wr_rd_full", 8'h77);
    check_state("wr_rd_full");
    send_valid(8'h11);
    check_state("overflow");
    drain("overflow");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a frame
    send_raw(8'h5A, 1'b0, 5);
    do_reset();
    check_state("mid_reset");
    send_valid(8'h3A);
    check_state("after_reset");
    drain("after_reset");

    // Randomized traffic with interleaved reads
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_valid(b);
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pop_check("rand");
    end
    check_state("rand_end");
    drain("rand_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
